// File: rtl/memory_matrix_core_if.sv
// Button, board-override and LED/status bundle between the memory game core and its board.
interface memory_matrix_core_if #(
  parameter int TILES = 16,
  parameter int CNT_W = 4
);
  logic             start;
  logic             give_up;
  logic             guess_add;
  logic [TILES-1:0] tiles_in;
  logic             use_fixed;
  logic [TILES-1:0] fixed_board;
  logic [TILES-1:0] board_led;
  logic             flash_led;
  logic [CNT_W-1:0] guesses_left;
  logic [3:0]       level;
  logic [3:0]       state_dbg;

  modport master (
    output start, give_up, guess_add, tiles_in, use_fixed, fixed_board,
    input  board_led, flash_led, guesses_left, level, state_dbg
  );

  modport slave (
    input  start, give_up, guess_add, tiles_in, use_fixed, fixed_board,
    output board_led, flash_led, guesses_left, level, state_dbg
  );
endinterface

// File: rtl/memory_matrix_core.sv
// Tile memory game: show a board, then the player must press exactly its tiles within a guess budget.
// Button presses act one cycle after their rising edge; outputs are registered state decoded combinationally.
module memory_matrix_core #(
  parameter int          TILES       = 16,
  parameter int          CNT_W       = 4,
  parameter int          SHOW_CYCLES = 50000000,
  parameter int          FLASH_HALF  = 12500000,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic                clk,
  input  logic                reset,
  memory_matrix_core_if.slave bus
);

  localparam int SW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam int FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam logic [SW-1:0]    SHOW_LAST  = SW'(SHOW_CYCLES - 1);
  localparam logic [FW-1:0]    FLASH_LAST = FW'(FLASH_HALF - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    LOAD = 4'd1,
    SHOW = 4'd2,
    PLAY = 4'd3,
    WIN  = 4'd4,
    LOSE = 4'd5
  } state_t;

  state_t           state, state_nx;
  logic             armed;
  logic             start_q, add_q;
  logic [TILES-1:0] tiles_q;
  logic [15:0]      lfsr;
  logic [CNT_W-1:0] gl, budget;
  logic [3:0]       lvl;
  logic [TILES-1:0] board, found;
  logic [SW-1:0]    show_cnt;
  logic [FW-1:0]    flash_cnt;
  logic             flash_q;

  logic             start_rise, add_rise;
  logic [TILES-1:0] tile_rise, new_board, lfsr_pick;
  logic             any_rise, multi_rise, on_board, play_eval, flashing;

  // armed blocks rise detection on the first cycle after reset release, so a
  // button held through reset is not taken as a fresh press
  assign start_rise = bus.start & ~start_q & armed;
  assign add_rise   = bus.guess_add & ~add_q & armed;
  assign tile_rise  = bus.tiles_in & ~tiles_q & {TILES{armed}};
  assign any_rise   = |tile_rise;
  assign multi_rise = |(tile_rise & (tile_rise - TILES'(1)));
  assign on_board   = |(tile_rise & board);
  assign lfsr_pick  = lfsr[TILES-1:0];
  assign new_board  = bus.use_fixed ? ((bus.fixed_board == '0) ? TILES'(1) : bus.fixed_board)
                                    : ((lfsr_pick == '0) ? TILES'(1) : lfsr_pick);
  assign play_eval  = (state == PLAY) && (state_nx == PLAY);
  assign flashing   = (state == IDLE) || (state == WIN) || (state == LOSE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start_rise) state_nx = LOAD;
      LOAD: if (start_rise && gl != '0) state_nx = SHOW;
      SHOW: if (show_cnt == SHOW_LAST) state_nx = PLAY;
      PLAY: begin
        if (bus.give_up)        state_nx = LOSE;
        else if (found == board) state_nx = WIN;
        else if (gl == '0)       state_nx = LOSE;
      end
      WIN:  if (start_rise) state_nx = SHOW;
      LOSE: if (start_rise) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.board_led    = '0;
    bus.flash_led    = flash_q;
    bus.guesses_left = gl;
    bus.level        = lvl;
    bus.state_dbg    = state;
    case (state)
      IDLE:       bus.board_led = {TILES{flash_q}};
      SHOW, LOSE: bus.board_led = board;
      PLAY, WIN:  bus.board_led = found;
      default:    bus.board_led = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      armed   <= 1'b0;
      start_q <= 1'b0;
      add_q   <= 1'b0;
      tiles_q <= '0;
      lfsr    <= SEED;
    end else begin
      armed   <= 1'b1;
      start_q <= bus.start;
      add_q   <= bus.guess_add;
      tiles_q <= bus.tiles_in;
      lfsr    <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gl     <= '0;
      budget <= '0;
      lvl    <= 4'd1;
      board  <= '0;
      found  <= '0;
    end else begin
      case (state)
        IDLE: if (start_rise) begin
          gl     <= '0;
          budget <= '0;
        end
        LOAD: begin
          if (start_rise && gl != '0) begin
            budget <= gl;
            board  <= new_board;
            found  <= '0;
          end else if (add_rise && gl != CNT_MAX) begin
            gl <= gl + CNT_W'(1);
          end
        end
        PLAY: begin
          if (state_nx == WIN && lvl != 4'd15) lvl <= lvl + 4'd1;
          // a repeat press on an already-found tile falls through with no effect
          if (play_eval && any_rise) begin
            if (multi_rise || !on_board) begin
              if (gl != '0) gl <= gl - CNT_W'(1);
            end else begin
              found <= found | tile_rise;
            end
          end
        end
        WIN: if (start_rise) begin
          gl    <= budget;
          board <= new_board;
          found <= '0;
        end
        LOSE: if (start_rise) lvl <= 4'd1;
        default: ;
      endcase
    end
  end

  // timers restart whenever the state changes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      show_cnt  <= '0;
      flash_cnt <= '0;
      flash_q   <= 1'b0;
    end else if (state_nx != state) begin
      show_cnt  <= '0;
      flash_cnt <= '0;
      flash_q   <= 1'b0;
    end else begin
      show_cnt <= (state == SHOW) ? show_cnt + SW'(1) : '0;
      if (flashing) begin
        if (flash_cnt == FLASH_LAST) begin
          flash_cnt <= '0;
          flash_q   <= ~flash_q;
        end else begin
          flash_cnt <= flash_cnt + FW'(1);
        end
      end else begin
        flash_cnt <= '0;
        flash_q   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_memory_matrix_core.sv
// Directed bench for memory_matrix_core: per-cycle vector table plus hand-written corner sequences.
module tb_memory_matrix_core;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_run = 0;
  int   n_fail = 0;

  memory_matrix_core_if #(.TILES(4), .CNT_W(4)) mif ();

  memory_matrix_core #(
    .TILES(4), .CNT_W(4), .SHOW_CYCLES(4), .FLASH_HALF(2), .SEED(16'hACE1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (mif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       give_up;
    logic       add;
    logic [3:0] tiles;
    logic [3:0] st;
    logic [3:0] gl;
    logic [3:0] lvl;
    logic [3:0] led;
    logic       flash;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic s, input logic g, input logic a, input logic [3:0] t,
                              input logic [3:0] st, input logic [3:0] gl, input logic [3:0] lv,
                              input logic [3:0] led, input logic fl);
    vec_t v;
    v.start = s; v.give_up = g; v.add = a; v.tiles = t;
    v.st = st; v.gl = gl; v.lvl = lv; v.led = led; v.flash = fl;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int st, input int gl, input int lv,
                         input int led, input int fl);
    chk({tag, " state"}, int'(mif.state_dbg), st);
    chk({tag, " guesses"}, int'(mif.guesses_left), gl);
    chk({tag, " level"}, int'(mif.level), lv);
    chk({tag, " board_led"}, int'(mif.board_led), led);
    chk({tag, " flash"}, int'(mif.flash_led), fl);
  endtask

  initial begin
    mif.start = 0; mif.give_up = 0; mif.guess_add = 0; mif.tiles_in = 4'b0000;
    mif.use_fixed = 1'b1; mif.fixed_board = 4'b0101;

    // start give_up add tiles | state gl level led flash
    vq.push_back(mk(0,0,0,4'b0000, 0,0,1,4'b0000,0));
    vq.push_back(mk(1,0,0,4'b0000, 1,0,1,4'b0000,0));
    vq.push_back(mk(0,0,1,4'b0000, 1,1,1,4'b0000,0));
    vq.push_back(mk(0,0,0,4'b0000, 1,1,1,4'b0000,0));
    vq.push_back(mk(0,0,1,4'b0000, 1,2,1,4'b0000,0));
    vq.push_back(mk(0,0,0,4'b0000, 1,2,1,4'b0000,0));
    vq.push_back(mk(0,0,1,4'b0000, 1,3,1,4'b0000,0));
    vq.push_back(mk(0,0,0,4'b0000, 1,3,1,4'b0000,0));
    vq.push_back(mk(1,0,0,4'b0000, 2,3,1,4'b0101,0));
    vq.push_back(mk(0,0,0,4'b0000, 2,3,1,4'b0101,0));
    vq.push_back(mk(0,1,0,4'b0000, 2,3,1,4'b0101,0));
    vq.push_back(mk(0,0,0,4'b0000, 2,3,1,4'b0101,0));
    vq.push_back(mk(0,0,0,4'b0000, 3,3,1,4'b0000,0));
    vq.push_back(mk(0,0,0,4'b0001, 3,3,1,4'b0001,0));
    vq.push_back(mk(0,0,0,4'b0000, 3,3,1,4'b0001,0));
    vq.push_back(mk(0,0,0,4'b0100, 3,3,1,4'b0101,0));
    vq.push_back(mk(0,0,0,4'b0000, 4,3,2,4'b0101,0));
    vq.push_back(mk(1,0,0,4'b0000, 2,3,2,4'b0101,0));
    vq.push_back(mk(0,0,0,4'b0000, 2,3,2,4'b0101,0));
    vq.push_back(mk(0,0,0,4'b0000, 2,3,2,4'b0101,0));
    vq.push_back(mk(0,0,0,4'b0000, 2,3,2,4'b0101,0));
    vq.push_back(mk(0,0,0,4'b0000, 3,3,2,4'b0000,0));
    vq.push_back(mk(0,0,0,4'b0011, 3,2,2,4'b0000,0));
    vq.push_back(mk(0,0,0,4'b0000, 3,2,2,4'b0000,0));
    vq.push_back(mk(0,0,0,4'b0001, 3,2,2,4'b0001,0));
    vq.push_back(mk(0,0,0,4'b0000, 3,2,2,4'b0001,0));
    vq.push_back(mk(0,0,0,4'b0001, 3,2,2,4'b0001,0));
    vq.push_back(mk(0,0,0,4'b0000, 3,2,2,4'b0001,0));
    vq.push_back(mk(0,1,0,4'b0100, 5,2,2,4'b0101,0));
    vq.push_back(mk(0,0,0,4'b0000, 5,2,2,4'b0101,0));
    vq.push_back(mk(1,0,0,4'b0000, 0,2,1,4'b0000,0));
    vq.push_back(mk(0,0,0,4'b0000, 0,2,1,4'b0000,0));
    vq.push_back(mk(0,0,0,4'b0000, 0,2,1,4'b1111,1));
    vq.push_back(mk(0,0,0,4'b0000, 0,2,1,4'b1111,1));
    vq.push_back(mk(0,0,0,4'b0000, 0,2,1,4'b0000,0));
    vq.push_back(mk(1,0,0,4'b0000, 1,0,1,4'b0000,0));
    vq.push_back(mk(0,0,0,4'b0000, 1,0,1,4'b0000,0));
    vq.push_back(mk(1,0,0,4'b0000, 1,0,1,4'b0000,0));
    vq.push_back(mk(0,0,1,4'b0000, 1,1,1,4'b0000,0));
    vq.push_back(mk(0,0,0,4'b0000, 1,1,1,4'b0000,0));
    vq.push_back(mk(0,0,1,4'b0000, 1,2,1,4'b0000,0));
    vq.push_back(mk(0,0,0,4'b0000, 1,2,1,4'b0000,0));
    vq.push_back(mk(1,0,0,4'b0000, 2,2,1,4'b0101,0));
    vq.push_back(mk(0,0,0,4'b0000, 2,2,1,4'b0101,0));
    vq.push_back(mk(0,0,0,4'b0000, 2,2,1,4'b0101,0));
    vq.push_back(mk(0,0,0,4'b0000, 2,2,1,4'b0101,0));
    vq.push_back(mk(0,0,0,4'b0000, 3,2,1,4'b0000,0));
    vq.push_back(mk(0,0,0,4'b0010, 3,1,1,4'b0000,0));
    vq.push_back(mk(0,0,0,4'b0000, 3,1,1,4'b0000,0));
    vq.push_back(mk(0,0,0,4'b1000, 3,0,1,4'b0000,0));
    vq.push_back(mk(0,0,0,4'b0000, 5,0,1,4'b0101,0));
    vq.push_back(mk(1,0,0,4'b0000, 0,0,1,4'b0000,0));

    #2 reset = 1'b0;
    #1 chk_all("reset", 0, 0, 1, 0, 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      mif.start = vq[i].start; mif.give_up = vq[i].give_up;
      mif.guess_add = vq[i].add; mif.tiles_in = vq[i].tiles;
      step();
      chk_all($sformatf("v%0d", i), int'(vq[i].st), int'(vq[i].gl), int'(vq[i].lvl),
              int'(vq[i].led), int'(vq[i].flash));
    end

    // guess budget saturates at 15
    mif.start = 0; step();
    mif.start = 1; step();
    mif.start = 0;
    chk("sat load state", int'(mif.state_dbg), 1);
    for (int k = 0; k < 20; k++) begin
      mif.guess_add = 1; step();
      mif.guess_add = 0; step();
    end
    chk("sat guesses", int'(mif.guesses_left), 15);

    // all-zero override board becomes tile 0
    mif.fixed_board = 4'b0000;
    mif.start = 1; step();
    chk("zero board led", int'(mif.board_led), 1);
    mif.start = 0;
    repeat (4) step();
    chk("zero board play", int'(mif.state_dbg), 3);
    mif.tiles_in = 4'b0010; step();
    chk("zero board miss", int'(mif.guesses_left), 14);
    mif.tiles_in = 4'b0000; step();
    mif.tiles_in = 4'b0001; step();
    chk("zero board hit", int'(mif.board_led), 1);
    mif.tiles_in = 4'b0000; step();
    chk("zero board win", int'(mif.state_dbg), 4);
    chk("zero board level", int'(mif.level), 2);

    // next round reloads the stored budget, not the depleted count
    mif.start = 1; step();
    chk("reload guesses", int'(mif.guesses_left), 15);
    mif.start = 0;
    repeat (4) step();
    chk("round2 play", int'(mif.state_dbg), 3);

    // asynchronous reset mid-PLAY with start held through release
    #3 reset = 1'b0;
    mif.start = 1;
    #1 chk_all("async reset", 0, 0, 1, 0, 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    step();
    chk("held start 1", int'(mif.state_dbg), 0);
    step();
    chk("held start 2", int'(mif.state_dbg), 0);
    mif.start = 0; step();
    mif.start = 1; step();
    chk("fresh start", int'(mif.state_dbg), 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
